// File: rtl/alu_pkg.sv
// Shared opcode and multiply/divide FSM encodings for the execute-stage ALU.
package alu_pkg;

  typedef enum logic [4:0] {
    OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_AND, OP_OR, OP_XOR, OP_NOR,
    OP_SLT, OP_SLTU, OP_SLL, OP_SRL, OP_SRA, OP_LUI,
    OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
    OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO
  } alu_op_t;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} mdu_state_t;

  function automatic logic is_mdu_op(input logic [4:0] op);
    return (op >= OP_MULT) && (op <= OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative multiply/divide: shift-add multiply, restoring divide, then sign fixup.
// The FIX state holds the corrected HI/LO on hi/lo with done high for one cycle.
module mdu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output mdu_state_t       state
);

  localparam int CW = $clog2(WIDTH) + 1;

  mdu_state_t         next_state;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] acc;
  logic               div_op, neg_lo, neg_hi, dbz;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   q_fix, r_fix;

  assign a_mag = (is_signed && a[WIDTH-1]) ? -a : a;
  assign b_mag = (is_signed && b[WIDTH-1]) ? -b : b;

  // acc holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV.
  assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
  assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, opnd};
  assign div_diff  = div_shift - {1'b0, opnd};

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:       if (start) next_state = is_div ? S_DIV : S_MUL;
      S_MUL, S_DIV: if (cnt == CW'(1)) next_state = S_FIX;
      S_FIX:        next_state = S_IDLE;
      default:      next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      opnd   <= '0;
      acc    <= '0;
      div_op <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      dbz    <= 1'b0;
    end else begin
      state <= next_state;
      case (state)
        S_IDLE: if (start) begin
          cnt    <= CW'(WIDTH);
          div_op <= is_div;
          opnd   <= b_mag;
          acc    <= {{WIDTH{1'b0}}, a_mag};
          neg_lo <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_hi <= is_signed & (is_div ? a[WIDTH-1] : (a[WIDTH-1] ^ b[WIDTH-1]));
          dbz    <= is_div & (b == '0);
        end
        S_MUL: begin
          acc <= {mul_sum, acc[WIDTH-1:1]};
          cnt <= cnt - 1'b1;
        end
        S_DIV: begin
          acc <= div_ge ? {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1}
                        : {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
          cnt <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // A zero divisor yields an all-ones quotient; the remainder path re-signs |a| back to a.
  assign prod_fix    = neg_lo ? -acc : acc;
  assign q_fix       = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign r_fix       = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  assign hi          = div_op ? r_fix : prod_fix[2*WIDTH-1:WIDTH];
  assign lo          = div_op ? (dbz ? '1 : q_fix) : prod_fix[WIDTH-1:0];
  assign done        = (state == S_FIX);
  assign div_by_zero = dbz;

endmodule

// File: rtl/alu_mdu.sv
// Execute-stage ALU: registered single-cycle ops, HI/LO, and the iterative MDU.
// Handshake: an op transfers on the edge where in_valid && in_ready; out_valid pulses one cycle.
module alu_mdu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic             accept, md_op;
  logic             mdu_done, mdu_dbz;
  logic [WIDTH-1:0] mdu_hi, mdu_lo;
  mdu_state_t       mdu_state;
  logic [WIDTH-1:0] sum, diff, alu_res;
  logic             alu_ovf;

  assign in_ready = (mdu_state == S_IDLE);
  assign accept   = in_valid && in_ready;
  assign md_op    = is_mdu_op(op);
  assign sum      = a + b;
  assign diff     = a - b;

  mdu_iter #(.WIDTH(WIDTH)) u_mdu (
    .clk         (clk),
    .rst         (rst),
    .start       (accept && md_op),
    .is_div      ((op == OP_DIV) || (op == OP_DIVU)),
    .is_signed   ((op == OP_MULT) || (op == OP_DIV)),
    .a           (a),
    .b           (b),
    .done        (mdu_done),
    .div_by_zero (mdu_dbz),
    .hi          (mdu_hi),
    .lo          (mdu_lo),
    .state       (mdu_state)
  );

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op)
      OP_ADD:  begin
        alu_res = sum;
        alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_ADDU: alu_res = sum;
      OP_SUB:  begin
        alu_res = diff;
        alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUBU: alu_res = diff;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_NOR:  alu_res = ~(a | b);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, a < b};
      // Shifts operate on a by shamt.
      OP_SLL:  alu_res = a << shamt;
      OP_SRL:  alu_res = a >> shamt;
      OP_SRA:  alu_res = $signed(a) >>> shamt;
      OP_LUI:  alu_res = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      OP_MFHI: alu_res = hi;
      OP_MFLO: alu_res = lo;
      OP_MTHI: alu_res = a;
      OP_MTLO: alu_res = a;
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      result      <= '0;
      zero        <= 1'b0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      out_valid   <= 1'b0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
      if (mdu_done) begin
        out_valid   <= 1'b1;
        result      <= mdu_lo;
        zero        <= (mdu_lo == '0);
        div_by_zero <= mdu_dbz;
        hi          <= mdu_hi;
        lo          <= mdu_lo;
      end else if (accept && !md_op) begin
        out_valid <= 1'b1;
        result    <= alu_res;
        zero      <= (alu_res == '0);
        overflow  <= alu_ovf;
        if (op == OP_MTHI) hi <= a;
        if (op == OP_MTLO) lo <= a;
      end
    end
  end

endmodule
